// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs - oversampling UART receiver with an RX FIFO.
//
// A 2-flop synchroniser feeds a bit-timing FSM. Each bit is sampled three
// times around its centre, and the receiver uses the majority of those
// three samples. A completed character is written into a first-word-fall-
// through FIFO as {ferr, perr, data}. The block also detects line breaks,
// raises a receive timeout when the line stays idle, and drives RTS for
// flow control.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   rx                  serial input (asynchronous, idles high)
//   cfg_en              receiver enable
//   cfg_div             clk cycles per oversample tick (0 behaves as 1)
//   cfg_data_bits       character length, clamped to [5, MAX_DATA_BITS]
//   cfg_parity_en/odd   parity bit present / odd parity
//   cfg_stop2           two stop bits
//   cfg_timeout         idle bit-times before timeout_irq (0 = disabled)
//   rx_data/perr/ferr   FIFO head entry, zero while the FIFO is empty
//   rx_valid, rx_ready  head handshake; the head is popped when both are high
//   fifo_level/full/empty  FIFO status
//   overrun, brk        one-cycle event pulses
//   timeout_irq         receive-timeout level
//   rts_n               registered flow control, low = ready to receive
//
// State table
//   IDLE    | waiting for a falling edge on the synced line
//   START   | start bit; a majority of 1 means a false start
//   DATA    | data bits, LSB first
//   PARITY  | parity bit
//   STOP1   | first stop bit; push here unless two stop bits are configured
//   STOP2   | second stop bit; push here
//   BRKWAIT | break seen, wait for the line to return high
module uart_rx_ovs #(
    parameter int MAX_DATA_BITS = 9,
    parameter int OVS           = 16,
    parameter int FIFO_DEPTH    = 16,
    parameter int DIV_W         = 16,
    parameter int RTS_MARGIN    = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               rx,
    input  logic                               cfg_en,
    input  logic [DIV_W-1:0]                   cfg_div,
    input  logic [3:0]                         cfg_data_bits,
    input  logic                               cfg_parity_en,
    input  logic                               cfg_parity_odd,
    input  logic                               cfg_stop2,
    input  logic [7:0]                         cfg_timeout,
    output logic [MAX_DATA_BITS-1:0]           rx_data,
    output logic                               rx_perr,
    output logic                               rx_ferr,
    output logic                               rx_valid,
    input  logic                               rx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               fifo_full,
    output logic                               fifo_empty,
    output logic                               overrun,
    output logic                               brk,
    output logic                               timeout_irq,
    output logic                               rts_n
);
    localparam int OVS_W = $clog2(OVS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH+1);
    localparam int ENT_W = MAX_DATA_BITS + 2;

    localparam logic [OVS_W-1:0] SAMP_A = OVS_W'(OVS/2 - 1);
    localparam logic [OVS_W-1:0] SAMP_B = OVS_W'(OVS/2);
    localparam logic [OVS_W-1:0] SAMP_C = OVS_W'(OVS/2 + 1);
    localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2, BRKWAIT
    } state_t;

    // synchroniser and edge history
    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // oversample tick generator
    logic [DIV_W-1:0] div_cnt, div_last;
    logic             tick;

    assign div_last = (cfg_div == '0) ? '0 : cfg_div - DIV_W'(1);
    // >= keeps the divider from running away if cfg_div shrinks mid-count
    assign tick     = cfg_en && (div_cnt >= div_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_cnt <= '0;
        else if (!cfg_en || tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DIV_W'(1);
    end

    // receive FSM
    state_t                   state;
    logic [OVS_W-1:0]         ovs_cnt;
    logic [3:0]               bit_cnt, n_bits;
    logic                     samp_a, samp_b, maj;
    logic [MAX_DATA_BITS-1:0] data_sr;
    logic                     par_bit, ferr_acc, saw_one;
    logic                     par_en, par_odd, stop2;
    logic                     push_req, start_det;
    logic [ENT_W-1:0]         push_entry;
    logic                     fin_ferr, fin_perr, fin_brk;

    assign maj      = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);
    assign fin_ferr = ferr_acc | ~maj;
    assign fin_perr = par_en & ((^data_sr ^ par_bit) != par_odd);
    // break: every majority after the start bit, including this last stop bit, was 0
    assign fin_brk  = ~saw_one & ~maj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ovs_cnt    <= '0;
            bit_cnt    <= '0;
            n_bits     <= 4'd8;
            samp_a     <= 1'b1;
            samp_b     <= 1'b1;
            data_sr    <= '0;
            par_bit    <= 1'b0;
            ferr_acc   <= 1'b0;
            saw_one    <= 1'b0;
            par_en     <= 1'b0;
            par_odd    <= 1'b0;
            stop2      <= 1'b0;
            push_req   <= 1'b0;
            push_entry <= '0;
            brk        <= 1'b0;
            start_det  <= 1'b0;
        end else begin
            push_req  <= 1'b0;
            brk       <= 1'b0;
            start_det <= 1'b0;
            if (!cfg_en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_prev && !rx_sync) begin
                            state     <= START;
                            start_det <= 1'b1;
                            ovs_cnt   <= '0;
                            bit_cnt   <= '0;
                            data_sr   <= '0;
                            par_bit   <= 1'b0;
                            ferr_acc  <= 1'b0;
                            saw_one   <= 1'b0;
                            par_en    <= cfg_parity_en;
                            par_odd   <= cfg_parity_odd;
                            stop2     <= cfg_stop2;
                            if (cfg_data_bits < 4'd5)
                                n_bits <= 4'd5;
                            else if (cfg_data_bits > 4'(MAX_DATA_BITS))
                                n_bits <= 4'(MAX_DATA_BITS);
                            else
                                n_bits <= cfg_data_bits;
                        end
                    end
                    BRKWAIT: begin
                        if (rx_sync)
                            state <= IDLE;
                    end
                    default: begin
                        if (tick) begin
                            ovs_cnt <= (ovs_cnt == OVS_LAST) ? '0 : ovs_cnt + OVS_W'(1);
                            if (ovs_cnt == SAMP_A)
                                samp_a <= rx_sync;
                            if (ovs_cnt == SAMP_B)
                                samp_b <= rx_sync;
                            if (ovs_cnt == SAMP_C) begin
                                if (state != START && maj)
                                    saw_one <= 1'b1;
                                if ((state == STOP1 || state == STOP2) && !maj)
                                    ferr_acc <= 1'b1;
                                case (state)
                                    START:   if (maj) state <= IDLE;
                                    DATA:    data_sr[bit_cnt] <= maj;
                                    PARITY:  par_bit <= maj;
                                    default: ;
                                endcase
                                if (state == STOP2 || (state == STOP1 && !stop2)) begin
                                    push_req <= 1'b1;
                                    if (fin_brk) begin
                                        push_entry <= {1'b1, 1'b0, {MAX_DATA_BITS{1'b0}}};
                                        brk        <= 1'b1;
                                        state      <= BRKWAIT;
                                    end else begin
                                        push_entry <= {fin_ferr, fin_perr, data_sr};
                                        state      <= IDLE;
                                    end
                                end
                            end
                            if (ovs_cnt == OVS_LAST) begin
                                case (state)
                                    START: begin
                                        state   <= DATA;
                                        bit_cnt <= '0;
                                    end
                                    DATA: begin
                                        if (bit_cnt == n_bits - 4'd1)
                                            state <= par_en ? PARITY : STOP1;
                                        else
                                            bit_cnt <= bit_cnt + 4'd1;
                                    end
                                    PARITY:  state <= STOP1;
                                    STOP1:   state <= STOP2;
                                    default: ;
                                endcase
                            end
                        end
                    end
                endcase
            end
        end
    end

    // FWFT FIFO
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;
    logic [ENT_W-1:0] head;

    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign rx_valid   = ~fifo_empty;
    assign do_pop     = rx_valid & rx_ready;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push    = push_req & (~fifo_full | do_pop);
    assign head       = mem[rd_ptr];
    assign rx_data    = rx_valid ? head[MAX_DATA_BITS-1:0] : '0;
    assign rx_perr    = rx_valid & head[MAX_DATA_BITS];
    assign rx_ferr    = rx_valid & head[MAX_DATA_BITS+1];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overrun    <= 1'b0;
        end else begin
            overrun <= push_req & ~do_push;
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: ;
            endcase
        end
    end

    // receive timeout: bit-times spent idle while data waits in the FIFO
    logic [OVS_W-1:0] idle_tick;
    logic [7:0]       idle_bits;
    logic             counting, to_clr;

    assign counting = rx_valid && (state == IDLE) && cfg_en;
    assign to_clr   = push_req | do_pop | start_det;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_tick   <= '0;
            idle_bits   <= '0;
            timeout_irq <= 1'b0;
        end else begin
            if (to_clr) begin
                idle_tick <= '0;
                idle_bits <= '0;
            end else if (counting && tick) begin
                if (idle_tick == OVS_LAST) begin
                    idle_tick <= '0;
                    if (idle_bits != 8'hFF)
                        idle_bits <= idle_bits + 8'd1;
                end else begin
                    idle_tick <= idle_tick + OVS_W'(1);
                end
            end
            if (push_req || do_pop)
                timeout_irq <= 1'b0;
            else if (cfg_timeout != 8'd0 && idle_bits >= cfg_timeout)
                timeout_irq <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rts_n <= 1'b1;
        else
            rts_n <= ~cfg_en | (fifo_level >= LVL_W'(FIFO_DEPTH - RTS_MARGIN));
    end

endmodule
